segway_math_pipe: RTL and testbench

- Parametrised, pipelined successor of the Segway balance-math block. It converts the PID controller output and the steering potentiometer into signed left/right motor speed commands.
- Owns its soft-start ramp internally, so there is no external ss_tmr input.
- Registers results behind a valid strobe. Debounces over-speed detection across consecutive samples.
- Sits between the PID controller and the motor-drive PWM/mtr_drv block.

---
 rtl/segway_pkg.sv | 26 ++
 rtl/segway_shape.sv | 31 +++
 rtl/segway_math_pipe.sv | 173 +++++++++++++++++
 tb/tb_segway_math_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/segway_pkg.sv
// Shared constants and helpers for the Segway balance-math pipeline.
// Optional slew limiting in segway_math_pipe is enabled by SEGWAY_SLEW_LIMIT_EN.
package segway_pkg;

    localparam int DEF_MIN_DUTY        = 960;
    localparam int DEF_LOW_TORQUE_BAND = 60;
    localparam int DEF_FAST_THRESH     = 1792;

    // Steering clip window in eighths of full scale, so it scales with SPD_W
    localparam int unsigned STEER_CLIP_LO_EIGHTHS = 1;
    localparam int unsigned STEER_CLIP_HI_EIGHTHS = 7;

    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                      input int width);
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
        min_v = -max_v - 32'sd1;
        if (value > max_v)
            return max_v;
        else if (value < min_v)
            return min_v;
        return value;
    endfunction

endpackage

// File: rtl/segway_shape.sv
// Deadzone compensation, low-torque gain and signed saturation for one motor side.
module segway_shape
    import segway_pkg::*;
#(
    parameter int SPD_W           = 12,
    parameter int MIN_DUTY        = DEF_MIN_DUTY,
    parameter int LOW_TORQUE_BAND = DEF_LOW_TORQUE_BAND,
    parameter int GAIN_MULT       = 16
) (
    input  logic [SPD_W:0]   torque,
    input  logic             pwr_up,
    output logic [SPD_W-1:0] shaped
);

    logic signed [31:0] t;
    logic signed [31:0] v;

    always_comb begin
        t = 32'($signed(torque));
        if (!pwr_up)
            v = '0;
        else if (t > LOW_TORQUE_BAND)
            v = t + MIN_DUTY;
        else if (t < -LOW_TORQUE_BAND)
            v = t - MIN_DUTY;
        else
            v = t * GAIN_MULT;
        shaped = SPD_W'(sat_signed(v, SPD_W));
    end

endmodule

// File: rtl/segway_math_pipe.sv
// Two-stage balance math: soft-start scaling and steering, then shaping and output.
// Define SEGWAY_SLEW_LIMIT_EN to rate-limit each output by SLEW_STEP per sample.
module segway_math_pipe
    import segway_pkg::*;
#(
    parameter int SPD_W           = 12,
    parameter int SS_W            = 8,
    parameter int MIN_DUTY        = DEF_MIN_DUTY,
    parameter int LOW_TORQUE_BAND = DEF_LOW_TORQUE_BAND,
    parameter int GAIN_MULT       = 16,
    parameter int FAST_THRESH     = DEF_FAST_THRESH,
    parameter int FAST_CNT        = 4,
    parameter int SLEW_STEP       = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    input  logic [SPD_W-1:0] PID_cntrl,
    input  logic [SPD_W-1:0] steer_pot,
    input  logic             en_steer,
    input  logic             pwr_up,
    output logic [SPD_W-1:0] lft_spd,
    output logic [SPD_W-1:0] rght_spd,
    output logic             spd_vld,
    output logic             too_fast
);

    localparam int PW = SPD_W + SS_W + 1;
    localparam int CW = $clog2(FAST_CNT + 1);
    localparam logic [SPD_W-1:0] CLIP_LO = SPD_W'(STEER_CLIP_LO_EIGHTHS << (SPD_W - 3));
    localparam logic [SPD_W-1:0] CLIP_HI = SPD_W'(STEER_CLIP_HI_EIGHTHS << (SPD_W - 3));
    localparam logic signed [SPD_W:0] STEER_MID = (SPD_W + 1)'((2 ** (SPD_W - 1)) - 1);
    localparam logic [SS_W-1:0] SS_MAX = '1;

    logic [SS_W-1:0]         ss_tmr;
    logic signed [SPD_W-1:0] pid_s;
    logic signed [SS_W:0]    ss_s;
    logic signed [PW-1:0]    prod;
    logic signed [SPD_W-1:0] pid_ss;
    logic [SPD_W-1:0]        steer_clip;
    logic signed [SPD_W:0]   steer_s;
    logic signed [SPD_W:0]   steer3;
    logic signed [SPD_W:0]   pid_ext;
    logic signed [SPD_W:0]   lft_torque;
    logic signed [SPD_W:0]   rght_torque;

    logic                    s1_vld;
    logic                    s1_pwr_up;
    logic signed [SPD_W:0]   s1_lft;
    logic signed [SPD_W:0]   s1_rght;

    logic [SPD_W-1:0]        shaped_lft;
    logic [SPD_W-1:0]        shaped_rght;
    logic [SPD_W-1:0]        lft_next;
    logic [SPD_W-1:0]        rght_next;
    logic                    over;
    logic [CW-1:0]           fast_cnt;
    logic [CW-1:0]           fast_next;

    always_comb begin
        pid_s   = $signed(PID_cntrl);
        ss_s    = $signed({1'b0, ss_tmr});
        prod    = PW'(pid_s) * PW'(ss_s);
        pid_ss  = SPD_W'(prod >>> SS_W);
        pid_ext = (SPD_W + 1)'(pid_ss);

        if (steer_pot < CLIP_LO)
            steer_clip = CLIP_LO;
        else if (steer_pot > CLIP_HI)
            steer_clip = CLIP_HI;
        else
            steer_clip = steer_pot;
        steer_s = $signed({1'b0, steer_clip}) - STEER_MID;
        steer3  = (steer_s >>> 4) + (steer_s >>> 3);

        lft_torque  = en_steer ? pid_ext + steer3 : pid_ext;
        rght_torque = en_steer ? pid_ext - steer3 : pid_ext;
    end

    // The sample is scaled by the pre-update soft-start value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_tmr    <= '0;
            s1_vld    <= 1'b0;
            s1_pwr_up <= 1'b0;
            s1_lft    <= '0;
            s1_rght   <= '0;
        end else begin
            s1_vld <= vld;
            if (vld) begin
                if (!pwr_up)
                    ss_tmr <= '0;
                else if (ss_tmr != SS_MAX)
                    ss_tmr <= ss_tmr + SS_W'(1);
                s1_pwr_up <= pwr_up;
                s1_lft    <= lft_torque;
                s1_rght   <= rght_torque;
            end
        end
    end

    segway_shape #(
        .SPD_W          (SPD_W),
        .MIN_DUTY       (MIN_DUTY),
        .LOW_TORQUE_BAND(LOW_TORQUE_BAND),
        .GAIN_MULT      (GAIN_MULT)
    ) u_shape_lft (
        .torque(s1_lft),
        .pwr_up(s1_pwr_up),
        .shaped(shaped_lft)
    );

    segway_shape #(
        .SPD_W          (SPD_W),
        .MIN_DUTY       (MIN_DUTY),
        .LOW_TORQUE_BAND(LOW_TORQUE_BAND),
        .GAIN_MULT      (GAIN_MULT)
    ) u_shape_rght (
        .torque(s1_rght),
        .pwr_up(s1_pwr_up),
        .shaped(shaped_rght)
    );

    function automatic logic [SPD_W-1:0] slew_limit(input logic [SPD_W-1:0] target,
                                                    input logic [SPD_W-1:0] prev);
        logic signed [31:0] diff;
        diff = 32'($signed(target)) - 32'($signed(prev));
        if (diff > SLEW_STEP)
            diff = SLEW_STEP;
        else if (diff < -SLEW_STEP)
            diff = -SLEW_STEP;
        return SPD_W'(32'($signed(prev)) + diff);
    endfunction

    // Over-speed is judged on the value about to be registered, so too_fast
    // rises together with the spd_vld that completes the run
    always_comb begin
`ifdef SEGWAY_SLEW_LIMIT_EN
        lft_next  = s1_pwr_up ? slew_limit(shaped_lft, lft_spd) : '0;
        rght_next = s1_pwr_up ? slew_limit(shaped_rght, rght_spd) : '0;
`else
        lft_next  = shaped_lft;
        rght_next = shaped_rght;
`endif
        over = (32'($signed(lft_next)) > FAST_THRESH) ||
               (32'($signed(rght_next)) > FAST_THRESH);
        if (!s1_pwr_up || !over)
            fast_next = '0;
        else if (fast_cnt == CW'(FAST_CNT))
            fast_next = fast_cnt;
        else
            fast_next = fast_cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
            too_fast <= 1'b0;
            fast_cnt <= '0;
        end else begin
            spd_vld <= s1_vld;
            if (s1_vld) begin
                lft_spd  <= lft_next;
                rght_spd <= rght_next;
                fast_cnt <= fast_next;
                too_fast <= (fast_next == CW'(FAST_CNT));
            end
        end
    end

endmodule

// File: tb/tb_segway_math_pipe.sv
// Directed plus randomized bench for segway_math_pipe against an arithmetic reference model.
module tb_segway_math_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [11:0] PID_cntrl;
    logic [11:0] steer_pot;
    logic        en_steer;
    logic        pwr_up;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        spd_vld;
    logic        too_fast;

    segway_math_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .vld      (vld),
        .PID_cntrl(PID_cntrl),
        .steer_pot(steer_pot),
        .en_steer (en_steer),
        .pwr_up   (pwr_up),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .spd_vld  (spd_vld),
        .too_fast (too_fast)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [11:0] l;
        logic [11:0] r;
        logic        tf;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          vld_pulses = 0;
    int          ss_m = 0;
    int          fc_m = 0;
    int          prev_l = 0;
    int          prev_r = 0;
    logic [11:0] hold_l = '0;
    logic [11:0] hold_r = '0;
    logic        hold_tf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int shape_m(input int t, input bit pwr);
        int v;
        if (!pwr) return 0;
        if (t > 60 || t < -60) v = (t > 0) ? t + 960 : t - 960;
        else v = t * 16;
        if (v > 2047) v = 2047;
        if (v < -2048) v = -2048;
        return v;
    endfunction

    function automatic int clamp_step(input int d);
        if (d > 64) return 64;
        if (d < -64) return -64;
        return d;
    endfunction

    // Drive one vld cycle and queue the result the reference model predicts
    task automatic step(input int pid, input int pot, input bit en, input bit pwr);
        int pss, clip, s, st3, lt, rt, l, r;
        exp_t e;
        PID_cntrl = 12'(pid);
        steer_pot = 12'(pot);
        en_steer  = en;
        pwr_up    = pwr;
        vld       = 1'b1;
        pss  = (pid * ss_m) >>> 8;
        clip = (pot < 512) ? 512 : ((pot > 3584) ? 3584 : pot);
        s    = clip - 2047;
        st3  = (s >>> 4) + (s >>> 3);
        lt   = en ? pss + st3 : pss;
        rt   = en ? pss - st3 : pss;
        l    = shape_m(lt, pwr);
        r    = shape_m(rt, pwr);
`ifdef SEGWAY_SLEW_LIMIT_EN
        if (pwr) begin
            l = prev_l + clamp_step(l - prev_l);
            r = prev_r + clamp_step(r - prev_r);
        end
`endif
        prev_l = l;
        prev_r = r;
        if (pwr && (l > 1792 || r > 1792)) fc_m = (fc_m < 4) ? fc_m + 1 : 4;
        else fc_m = 0;
        ss_m = pwr ? ((ss_m < 255) ? ss_m + 1 : 255) : 0;
        e.due = cyc + 2;
        e.l   = 12'(l);
        e.r   = 12'(r);
        e.tf  = (fc_m == 4);
        q.push_back(e);
        @(posedge clk);
        #1;
        vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (spd_vld) begin
                    vld_pulses++;
                    chk("spd_vld_expected", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("latency", cyc, e.due);
                        chk("lft_spd", 32'(lft_spd), 32'(e.l));
                        chk("rght_spd", 32'(rght_spd), 32'(e.r));
                        chk("too_fast", 32'(too_fast), 32'(e.tf));
                        hold_l  = e.l;
                        hold_r  = e.r;
                        hold_tf = e.tf;
                    end
                end else begin
                    chk("hold_lft", 32'(lft_spd), 32'(hold_l));
                    chk("hold_rght", 32'(rght_spd), 32'(hold_r));
                    chk("hold_too_fast", 32'(too_fast), 32'(hold_tf));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        rst = 1'b1; vld = 1'b0; PID_cntrl = '0; steer_pot = '0; en_steer = 1'b0; pwr_up = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_lft", 32'(lft_spd), 32'd0);
        chk("rst_rght", 32'(rght_spd), 32'd0);
        chk("rst_spd_vld", 32'(spd_vld), 32'd0);
        chk("rst_too_fast", 32'(too_fast), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        step(12'h100, 12'h800, 1'b0, 1'b1);
        drain();
        chk("first_sample_lft", 32'(lft_spd), 32'd0);
        chk("first_sample_rght", 32'(rght_spd), 32'd0);

        for (int i = 0; i < 260; i++)
            step(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)),
                 1'($urandom_range(0, 1)), 1'b1);
        drain();

`ifndef SEGWAY_SLEW_LIMIT_EN
        step(12'h100, 12'h800, 1'b0, 1'b1);
        drain();
        chk("fullscale_lft", 32'(lft_spd), 32'h4BF);
        chk("fullscale_rght", 32'(rght_spd), 32'h4BF);
        step(32'sh20, 12'h800, 1'b0, 1'b1);
        drain();
        chk("lowgain_pos", 32'(lft_spd), 32'h1F0);
        step(-32'sh20, 12'h800, 1'b0, 1'b1);
        drain();
        chk("lowgain_neg", 32'(rght_spd), 32'hE00);
        step(0, 12'hFFF, 1'b1, 1'b1);
        drain();
        chk("steer_lft", 32'(lft_spd), 32'h4E0);
        chk("steer_rght", 32'(rght_spd), 32'hB20);
        step(0, 12'hFFF, 1'b0, 1'b1);
        drain();
        chk("nosteer_lft", 32'(lft_spd), 32'd0);
        for (int i = 0; i < 3; i++) step(12'h7FF, 12'h800, 1'b0, 1'b1);
        drain();
        chk("sat_lft", 32'(lft_spd), 32'h7FF);
        chk("too_fast_after3", 32'(too_fast), 32'd0);
        step(12'h7FF, 12'h800, 1'b0, 1'b1);
        drain();
        chk("too_fast_after4", 32'(too_fast), 32'd1);
        step(0, 12'h800, 1'b0, 1'b1);
        drain();
        chk("too_fast_cleared", 32'(too_fast), 32'd0);
`else
        step(0, 12'h800, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) step(0, 12'h800, 1'b0, 1'b1);
        drain();
        for (int i = 1; i <= 3; i++) begin
            step(12'h100, 12'h800, 1'b0, 1'b1);
            drain();
            chk("slew_ramp", 32'(lft_spd), 32'(64 * i));
        end
`endif

        step(12'h7FF, 12'h800, 1'b0, 1'b0);
        drain();
        chk("pwrdn_lft", 32'(lft_spd), 32'd0);
        chk("pwrdn_rght", 32'(rght_spd), 32'd0);
        step(12'h7FF, 12'h800, 1'b0, 1'b1);
        drain();
        chk("pwrdn_ss_cleared", 32'(lft_spd), 32'd0);

        for (int i = 0; i < 300; i++) begin
            step(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 31) != 0));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        drain();

        n0 = vld_pulses;
        step(12'h7FF, 12'hFFF, 1'b1, 1'b1);
        rst = 1'b1;
        q.delete();
        ss_m = 0; fc_m = 0; prev_l = 0; prev_r = 0;
        hold_l = '0; hold_r = '0; hold_tf = 1'b0;
        @(negedge clk);
        chk("midrst_lft", 32'(lft_spd), 32'd0);
        chk("midrst_rght", 32'(rght_spd), 32'd0);
        chk("midrst_too_fast", 32'(too_fast), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        chk("midrst_no_spd_vld", vld_pulses, n0);
        step(12'h7FF, 12'h800, 1'b0, 1'b1);
        drain();
        chk("post_rst_ss_zero", 32'(lft_spd), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
